// File: rtl/flag_unit_pkg.sv
// Shared encodings for the flag unit: ALU ops, flag bit positions,
// branch condition codes and which flags each op is allowed to write.
package flag_unit_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_PADDSB = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_XOR    = 3'b111;

  localparam int FLAG_N = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;

  localparam logic [2:0] COND_NEQ    = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GTE    = 3'b100;
  localparam logic [2:0] COND_LTE    = 3'b101;
  localparam logic [2:0] COND_OVFL   = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  // Entry k is the write mask for op k; bit order matches the flag vector.
  localparam logic [7:0][2:0] UPD_MASK = {
    3'b100,   // XOR
    3'b100,   // ROR
    3'b100,   // SRA
    3'b100,   // SLL
    3'b000,   // RED
    3'b000,   // PADDSB
    3'b111,   // SUB
    3'b111    // ADD
  };

  function automatic logic [2:0] upd_mask_of(input logic [2:0] op);
    return UPD_MASK[op];
  endfunction

endpackage

// File: rtl/flag_unit_if.sv
// EX/decode-side signals of the flag unit; master drives the pipeline side.
interface flag_unit_if;
  logic [2:0] alu_ctl;
  logic [2:0] alu_flags;
  logic       ex_valid;
  logic       ex_stall;
  logic       ex_flush;
  logic       br_valid;
  logic [2:0] br_cond;
  logic [2:0] flags_q;
  logic [2:0] flags_eff;
  logic [2:0] upd_mask;
  logic       br_taken;

  modport master (
    output alu_ctl, alu_flags, ex_valid, ex_stall, ex_flush, br_valid, br_cond,
    input  flags_q, flags_eff, upd_mask, br_taken
  );

  modport slave (
    input  alu_ctl, alu_flags, ex_valid, ex_stall, ex_flush, br_valid, br_cond,
    output flags_q, flags_eff, upd_mask, br_taken
  );
endinterface

// File: rtl/flag_unit_br_cond_eval.sv
// Combinational branch condition evaluator over an N/V/Z flag vector.
module br_cond_eval
  import flag_unit_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  input  logic       valid,
  output logic       taken
);

  logic n, v, z;

  always_comb begin
    n = flags[FLAG_N];
    v = flags[FLAG_V];
    z = flags[FLAG_Z];
    taken = 1'b0;
    if (valid) begin
      case (cond)
        COND_NEQ:    taken = ~z;
        COND_EQ:     taken = z;
        COND_GT:     taken = ~z & ~n;
        COND_LT:     taken = n;
        COND_GTE:    taken = z | ~n;
        COND_LTE:    taken = n | z;
        COND_OVFL:   taken = v;
        default:     taken = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/flag_unit.sv
// Architectural N/V/Z flag register with same-cycle forwarding to the
// decode-stage branch evaluator.
module flag_unit
  import flag_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  flag_unit_if.slave  bus
);

  logic       commit;
  logic [2:0] upd_mask;
  logic [2:0] flags_d;
  logic [2:0] flags_q_q;
  logic       br_taken;

  // flags_d doubles as the forwarded view: it is what the register will hold next.
  always_comb begin
    commit   = bus.ex_valid & ~bus.ex_stall & ~bus.ex_flush;
    upd_mask = commit ? upd_mask_of(bus.alu_ctl) : 3'b000;
    for (int i = 0; i < 3; i++) begin
      flags_d[i] = upd_mask[i] ? bus.alu_flags[i] : flags_q_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q_q <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (upd_mask[i]) flags_q_q[i] <= bus.alu_flags[i];
      end
    end
  end

  br_cond_eval u_br_cond_eval (
    .flags (flags_d),
    .cond  (bus.br_cond),
    .valid (bus.br_valid),
    .taken (br_taken)
  );

  assign bus.flags_q   = flags_q_q;
  assign bus.flags_eff = flags_d;
  assign bus.upd_mask  = upd_mask;
  assign bus.br_taken  = br_taken;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios plus a randomized run
// against a behavioural model of the flag rules.
module tb_flag_unit;
  import flag_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flag_unit_if bus();

  flag_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [2:0] m_flags;   // model of the architectural register {Z,V,N}

  function automatic logic [2:0] m_mask(input logic v, s, f, input logic [2:0] op);
    if (!v || s || f) return 3'b000;
    if (op == OP_ADD || op == OP_SUB) return 3'b111;
    if (op == OP_PADDSB || op == OP_RED) return 3'b000;
    return 3'b100;
  endfunction

  function automatic logic [2:0] m_eff(input logic [2:0] mask, alu, reg_f);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = mask[i] ? alu[i] : reg_f[i];
    return r;
  endfunction

  function automatic logic m_taken(input logic [2:0] fl, input logic [2:0] c, input logic bv);
    bit n, v, z;
    n = fl[0]; v = fl[1]; z = fl[2];
    if (!bv) return 1'b0;
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic drive(input logic r, v, s, f, input logic [2:0] op, fl,
                       input logic bv, input logic [2:0] bc);
    @(negedge clk);
    rst = r; bus.ex_valid = v; bus.ex_stall = s; bus.ex_flush = f;
    bus.alu_ctl = op; bus.alu_flags = fl; bus.br_valid = bv; bus.br_cond = bc;
    #1;
  endtask

  task automatic tick();
    logic [2:0] mk;
    @(posedge clk);
    mk = m_mask(bus.ex_valid, bus.ex_stall, bus.ex_flush, bus.alu_ctl);
    m_flags = rst ? 3'b000 : m_eff(mk, bus.alu_flags, m_flags);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, OP_ADD, 3'b111, 1'b0, 3'b000);
      n_chk++;
      if (bus.upd_mask !== 3'b111) $display("FAIL reset_upd_mask got %b want 111", bus.upd_mask);
      else n_pass++;
      n_chk++;
      if (bus.flags_eff !== 3'b111) $display("FAIL reset_flags_eff got %b want 111", bus.flags_eff);
      else n_pass++;
      tick();
      n_chk++;
      if (bus.flags_q !== 3'b000) $display("FAIL reset_flags_q got %b want 000", bus.flags_q);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, 3'b111, 1'b0, 3'b000);
    n_chk++;
    if (bus.flags_q !== 3'b000) $display("FAIL reset_release got %b want 000", bus.flags_q);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 3'b101, 1'b0, 3'b000);
    tick();
    n_chk++;
    if (bus.flags_q !== 3'b101) $display("FAIL reset_first_commit got %b want 101", bus.flags_q);
    else n_pass++;
  endtask

  task automatic test_partial();
    drive(1'b0, 1'b1, 1'b0, 1'b0, OP_SUB, 3'b011, 1'b0, 3'b000);
    tick();
    n_chk++;
    if (bus.flags_q !== 3'b011) $display("FAIL partial_sub got %b want 011", bus.flags_q);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b0, 1'b0, OP_XOR, 3'b100, 1'b0, 3'b000);
    n_chk++;
    if (bus.upd_mask !== 3'b100) $display("FAIL partial_xor_mask got %b want 100", bus.upd_mask);
    else n_pass++;
    tick();
    n_chk++;
    if (bus.flags_q !== 3'b111) $display("FAIL partial_xor got %b want 111", bus.flags_q);
    else n_pass++;
  endtask

  task automatic test_forward();
    drive(1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 3'b000, 1'b0, 3'b000);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 3'b100, 1'b1, COND_EQ);
    n_chk++;
    if (bus.br_taken !== 1'b1) $display("FAIL forward_taken got %b want 1", bus.br_taken);
    else n_pass++;
    n_chk++;
    if (bus.flags_eff !== 3'b100) $display("FAIL forward_eff got %b want 100", bus.flags_eff);
    else n_pass++;
    n_chk++;
    if (bus.flags_q !== 3'b000) $display("FAIL forward_reg_before got %b want 000", bus.flags_q);
    else n_pass++;
    tick();
  endtask

  task automatic test_stall_flush();
    logic [1:0] sf [3] = '{2'b10, 2'b01, 2'b11};
    drive(1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 3'b001, 1'b0, 3'b000);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, sf[k][1], sf[k][0], OP_ADD, 3'b100, 1'b1, COND_LT);
      n_chk++;
      if (bus.br_taken !== 1'b1) $display("FAIL stallflush_taken[%0d] got %b want 1", k, bus.br_taken);
      else n_pass++;
      n_chk++;
      if (bus.upd_mask !== 3'b000 || bus.flags_eff !== 3'b001)
        $display("FAIL stallflush_comb[%0d] got mask %b eff %b want 000 001", k, bus.upd_mask, bus.flags_eff);
      else n_pass++;
      tick();
      n_chk++;
      if (bus.flags_q !== 3'b001) $display("FAIL stallflush_hold[%0d] got %b want 001", k, bus.flags_q);
      else n_pass++;
    end
  endtask

  task automatic test_no_update();
    logic [2:0] ops [2] = '{OP_RED, OP_PADDSB};
    drive(1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 3'b000, 1'b0, 3'b000);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, ops[k], 3'b111, 1'b0, 3'b000);
      n_chk++;
      if (bus.upd_mask !== 3'b000) $display("FAIL noupd_mask[%0d] got %b want 000", k, bus.upd_mask);
      else n_pass++;
      tick();
      n_chk++;
      if (bus.flags_q !== 3'b000) $display("FAIL noupd_flags[%0d] got %b want 000", k, bus.flags_q);
      else n_pass++;
    end
  endtask

  task automatic test_cond_sweep();
    for (int f = 0; f < 8; f++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, OP_ADD, 3'(f), 1'b0, 3'b000);
      tick();
      for (int c = 0; c < 8; c++) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, 3'(~f), 1'b1, 3'(c));
        n_chk++;
        if (bus.br_taken !== m_taken(3'(f), 3'(c), 1'b1))
          $display("FAIL sweep flags=%0d cond=%0d got %b want %b", f, c, bus.br_taken,
                   m_taken(3'(f), 3'(c), 1'b1));
        else n_pass++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, OP_ADD, 3'(f), 1'b0, 3'(c));
        n_chk++;
        if (bus.br_taken !== 1'b0) $display("FAIL sweep_invalid cond=%0d got %b want 0", c, bus.br_taken);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] mk, eff;
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 15) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom), 1'($urandom), 3'($urandom));
      mk  = m_mask(bus.ex_valid, bus.ex_stall, bus.ex_flush, bus.alu_ctl);
      eff = m_eff(mk, bus.alu_flags, m_flags);
      n_chk++;
      if (bus.upd_mask !== mk || bus.flags_eff !== eff || bus.br_taken !== m_taken(eff, bus.br_cond, bus.br_valid))
        $display("FAIL rand_comb[%0d] got mask %b eff %b tk %b want %b %b %b", k, bus.upd_mask,
                 bus.flags_eff, bus.br_taken, mk, eff, m_taken(eff, bus.br_cond, bus.br_valid));
      else n_pass++;
      tick();
      n_chk++;
      if (bus.flags_q !== m_flags) $display("FAIL rand_flags_q[%0d] got %b want %b", k, bus.flags_q, m_flags);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_stall = 1'b0; bus.ex_flush = 1'b0;
    bus.alu_ctl = OP_ADD; bus.alu_flags = 3'b000; bus.br_valid = 1'b0; bus.br_cond = 3'b000;
    m_flags = 3'b000;
    test_reset();
    test_partial();
    test_forward();
    test_stall_flush();
    test_no_update();
    test_cond_sweep();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst (one clock; reset is synchronous and active-high).
REQ-002 The block SHALL provide these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- alu_ctl  in  3  EX-stage ALU op: 000 ADD, 001 SUB, 010 PADDSB, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 XOR
- alu_flags  in  3  ALU flags from the same cycle: [0] N, [1] V, [2] Z
- ex_valid  in  1  EX stage holds a real instruction
- ex_stall  in  1  EX instruction does not retire this cycle
- ex_flush  in  1  EX instruction is squashed
- br_valid  in  1  decode stage holds a conditional branch
- br_cond  in  3  branch condition code
- flags_q  out  3  architectural flag register, same bit order as alu_flags
- flags_eff  out  3  forwarded flags seen by decode this cycle
- upd_mask  out  3  per-bit write enables applied this cycle
- br_taken  out  1  branch condition true; combinational

Function
REQ-003 The block SHALL commit an EX instruction only when commit = ex_valid & ~ex_stall & ~ex_flush.
REQ-004 The per-op update mask SHALL be:
- ADD/SUB: N, V, Z
- XOR/SLL/SRA/ROR: Z only
- PADDSB/RED: none
REQ-005 upd_mask SHALL equal the per-op mask when commit=1, and 000 otherwise.
REQ-006 On each rising edge, bit i of flags_q SHALL load alu_flags[i] if upd_mask[i]=1; otherwise it SHALL hold.
REQ-007 Update latency SHALL be one cycle: a committed flag is visible on flags_q in the cycle after commit.
REQ-008 flags_eff[i] SHALL be alu_flags[i] when upd_mask[i]=1, and flags_q[i] otherwise; this forwarding is combinational within the same cycle.
REQ-009 br_taken SHALL be 0 when br_valid=0. Otherwise it SHALL evaluate flags_eff as follows:
- 000 NEQ: ~Z
- 001 EQ: Z
- 010 GT: ~Z & ~N
- 011 LT: N
- 100 GTE: Z | ~N
- 101 LTE: N | Z
- 110 OVFL: V
- 111 UNCOND: 1
REQ-010 When ex_flush=1 and ex_stall=1 together, flush SHALL win: no update occurs, and forwarding falls back to flags_q.
REQ-011 When ex_stall=1, the block SHALL hold flags_q, and br_taken SHALL use flags_q.
REQ-012 ex_valid=0 SHALL behave as a bubble: no update and no forwarding, regardless of alu_ctl or alu_flags.
REQ-013 Back-to-back commits SHALL each apply their own mask; a Z-only op SHALL preserve N and V written by the prior ADD/SUB.
REQ-014 The block SHALL impose no stall of its own; a branch in decode SHALL resolve in the same cycle as the flag-setting op in EX.

Reset
REQ-015 While rst=1 at a clock edge, flags_q SHALL become 000, and a commit in that cycle SHALL be discarded.
REQ-016 During reset, upd_mask and flags_eff SHALL follow REQ-005 and REQ-008 combinationally; only the register is forced.
REQ-017 After reset deasserts, the first committed op SHALL update flags_q normally on the next edge.

Structure
REQ-018 The following SHALL live in a shared package:
- ALU op encodings
- flag bit indices (N=0, V=1, Z=2)
- branch condition encodings
- per-op update-mask constant
REQ-019 Condition evaluation SHALL be a sub-module, br_cond_eval (in: flags, cond, valid; out: taken).
REQ-020 The block SHALL contain exactly one 3-bit flag register with per-bit enables.

Verification
REQ-021 Reset:
- stimulus: rst=1 for 2 cycles with ex_valid=1, ADD, alu_flags=111
- required response: flags_q=000 on release
REQ-022 Partial update:
- stimulus: commit SUB with alu_flags=011, then XOR with alu_flags=100
- required response: flags_q=011, then 111
REQ-023 Forwarding:
- stimulus: flags_q=000; same cycle ADD commit with alu_flags=100, br_valid=1, br_cond=001
- required response: br_taken=1 and flags_eff=100
REQ-024 Stall/flush:
- stimulus: flags_q=001; ADD with alu_flags=100 and ex_stall=1, then ex_flush=1, then both asserted
- required response: flags_q stays 001; br_cond=011 gives br_taken=1 throughout
REQ-025 No-update ops:
- stimulus: RED and PADDSB commits with alu_flags=111 from flags_q=000
- required response: flags_q=000 and upd_mask=000
REQ-026 Condition sweep:
- stimulus: all 8 br_cond against all 8 flag values, plus br_valid=0
- required response: matches the REQ-009 table; br_valid=0 gives br_taken=0
